matrix_frame_capture: RTL
=========================

// Module: matrix_frame_capture
// PURPOSE
//  Receiving end of the 16x16 LED-matrix serial link driven by the pong core
//  (RCLK/RSDI row chain, CCLK/CSDI column chain, LE latch, OEB blank).
//  Models the two 16-bit shift/latch chains, decodes each latched row and
//  stores its column pattern in a 16x16 frame buffer. Host/LA reads it back.
//  Used for on-chip self-check of the display path and as bench scoreboard.
// PARAMETERS
//  WIDTH        16  shift chain length = matrix rows = matrix columns
//  SYNC_STAGES  2   synchroniser flops on each serial input (>=2)
//  CNT_W        8   width of frame_count (wraps)
// PORTS
//  clk          in   1      system clock (wb_clk_i at the wrapper)
//  reset        in   1      asynchronous, active-high reset
//  RCLK         in   1      row shift clock (async to clk)
//  RSDI         in   1      row serial data
//  CCLK         in   1      column shift clock
//  CSDI         in   1      column serial data
//  LE           in   1      latch enable, rising edge transfers both chains
//  OEB          in   1      output enable, active low
//  err_clr      in   1      synchronous clear of sticky error flags
//  rd_row       in   4      frame buffer read address
//  rd_data      out  WIDTH  column pattern of rd_row, registered
//  row_latch    out  WIDTH  current row latch contents
//  col_latch    out  WIDTH  current column latch contents
//  row_wr       out  1      1-cycle pulse: frame buffer row written
//  frame_done   out  1      1-cycle pulse: row 15 written
//  frame_count  out  CNT_W  frame_done count, wraps 255->0
//  blank        out  1      synchronised OEB (1 = display dark)
//  err_multi    out  1      sticky: latched row had >1 bit set
//  err_len      out  1      sticky: shift count at LE != WIDTH on either chain
// BEHAVIOUR
//  - Reset: all shift regs, latches, frame buffer, counters, rd_data,
//    row_wr, frame_done, err_* = 0; blank = 1 (OEB sync flops reset to 1).
//  - All six serial inputs pass SYNC_STAGES flops; edges detected on
//    synced value vs 1-cycle-delayed copy. Sender keeps each clock phase and
//    data setup >= SYNC_STAGES+1 clk cycles; faster links are out of spec.
//  - RCLK rising edge: row_sr <= {row_sr[WIDTH-2:0], RSDI_s}; rcnt+1,
//    saturating at 31. CCLK likewise for col_sr/ccnt. First bit shifted
//    ends in bit WIDTH-1 after WIDTH shifts.
//  - LE rising edge: row_latch<=row_sr, col_latch<=col_sr; err_len set if
//    rcnt!=WIDTH or ccnt!=WIDTH; rcnt,ccnt cleared. Shift regs NOT cleared.
//  - LE edge same cycle as RCLK/CCLK edge: latch takes pre-shift value;
//    that shift counts as 1 in the new count (74HC595 semantics).
//  - Decode, cycle after latch update: row_latch==0 -> no write, no error;
//    exactly one bit k set -> frame[k]<=col_latch, row_wr pulses 1 cycle;
//    >1 bit set -> no write, err_multi set.
//  - Write to row 15 also pulses frame_done (same cycle as row_wr) and
//    increments frame_count. Rows may arrive in any order.
//  - Latency: LE pin rise to row_wr pulse = SYNC_STAGES+2 clk edges.
//  - Read: rd_data <= frame[rd_row] every cycle (1-cycle latency).
//    Same-cycle write to rd_row: rd_data returns old value, new next cycle.
//  - err_clr clears err_multi/err_len; a set event in the same cycle wins.
//  - blank = OEB_s; purely informational, does not gate capture.
//  - Reset mid-shift: partial bits discarded; capture resumes with next
//    RCLK/CCLK edge from count 0.
// TESTING
//  1 Reset -> rd_data=0 all rows, blank=1, frame_count=0, err_*=0.
//  2 Shift row 0x0008, col 0xA5F0 (16 clocks each), pulse LE -> one
//    row_wr, rd_row=3 gives 0xA5F0, err_len=0, frame_done=0.
//  3 Full frame rows 0..15 col=0x1111*(r%16) -> one frame_done after row 15,
//    frame_count=1; all 16 rows read back correctly.
//  4 Row 0x0300 latched -> no row_wr, err_multi=1, buffer unchanged;
//    err_clr pulse -> err_multi=0.
//  5 Only 15 RCLK shifts before LE -> err_len=1; row 0x0000 -> no write.
//  6 LE rising same sync cycle as 16th CCLK edge -> col_latch = pre-shift
//    value, ccnt=1 afterwards; reset asserted mid-frame clears everything.

Source files
------------

// File: rtl/matrix_frame_capture_if.sv
// rtl/matrix_frame_capture_if.sv - serial LED-matrix link (row/column chains, latch, blank)
interface matrix_frame_capture_if;
   logic RCLK;
   logic RSDI;
   logic CCLK;
   logic CSDI;
   logic LE;
   logic OEB;

   modport master (output RCLK, RSDI, CCLK, CSDI, LE, OEB);
   modport slave  (input  RCLK, RSDI, CCLK, CSDI, LE, OEB);
endinterface

// File: rtl/matrix_frame_capture.sv
// rtl/matrix_frame_capture.sv - captures the LED-matrix serial link into a 16x16 frame buffer
module matrix_frame_capture #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   matrix_frame_capture_if.slave      link,
   input  logic                       err_clr,
   input  logic [$clog2(WIDTH)-1:0]   rd_row,
   output logic [WIDTH-1:0]           rd_data,
   output logic [WIDTH-1:0]           row_latch,
   output logic [WIDTH-1:0]           col_latch,
   output logic                       row_wr,
   output logic                       frame_done,
   output logic [CNT_W-1:0]           frame_count,
   output logic                       blank,
   output logic                       err_multi,
   output logic                       err_len
);
   localparam int          AW       = $clog2(WIDTH);
   localparam logic [4:0]  CNT_MAX  = 5'd31;
   localparam logic [4:0]  CNT_FULL = 5'(WIDTH);
   // bit order {OEB, LE, CSDI, CCLK, RSDI, RCLK}; OEB idles high so the display starts dark
   localparam logic [5:0]  SYNC_RST = 6'b100000;

   logic [5:0]       w_in;
   logic [5:0]       w_s;
   logic [5:0]       r_sync [SYNC_STAGES];
   logic [5:0]       r_prev;
   logic             w_rclk_rise;
   logic             w_cclk_rise;
   logic             w_le_rise;

   logic [WIDTH-1:0] r_row_sr;
   logic [WIDTH-1:0] r_col_sr;
   logic [4:0]       r_rcnt;
   logic [4:0]       r_ccnt;
   logic [WIDTH-1:0] r_row_latch;
   logic [WIDTH-1:0] r_col_latch;
   logic             r_dec;

   logic [AW-1:0]    w_idx;
   logic             w_nz;
   logic             w_multi;
   logic             w_wr;
   logic             w_len_bad;

   logic [WIDTH-1:0] r_frame [WIDTH];
   logic [WIDTH-1:0] r_rd_data;
   logic             r_row_wr;
   logic             r_frame_done;
   logic [CNT_W-1:0] r_frame_count;
   logic             r_err_multi;
   logic             r_err_len;

   assign w_in = {link.OEB, link.LE, link.CSDI, link.CCLK, link.RSDI, link.RCLK};
   assign w_s  = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
         r_prev <= SYNC_RST;
      end else begin
         r_sync[0] <= w_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= w_s;
      end
   end

   assign w_rclk_rise = w_s[0] & ~r_prev[0];
   assign w_cclk_rise = w_s[2] & ~r_prev[2];
   assign w_le_rise   = w_s[4] & ~r_prev[4];
   assign w_len_bad   = w_le_rise & ((r_rcnt != CNT_FULL) | (r_ccnt != CNT_FULL));

   // a shift coinciding with LE lands after the latch and starts the new count at 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row_sr    <= '0;
         r_col_sr    <= '0;
         r_rcnt      <= '0;
         r_ccnt      <= '0;
         r_row_latch <= '0;
         r_col_latch <= '0;
         r_dec       <= 1'b0;
      end else begin
         if (w_rclk_rise) r_row_sr <= {r_row_sr[WIDTH-2:0], w_s[1]};
         if (w_cclk_rise) r_col_sr <= {r_col_sr[WIDTH-2:0], w_s[3]};
         if (w_le_rise) begin
            r_row_latch <= r_row_sr;
            r_col_latch <= r_col_sr;
            r_rcnt      <= w_rclk_rise ? 5'd1 : 5'd0;
            r_ccnt      <= w_cclk_rise ? 5'd1 : 5'd0;
         end else begin
            if (w_rclk_rise && r_rcnt != CNT_MAX) r_rcnt <= r_rcnt + 5'd1;
            if (w_cclk_rise && r_ccnt != CNT_MAX) r_ccnt <= r_ccnt + 5'd1;
         end
         r_dec <= w_le_rise;
      end
   end

   always_comb begin
      w_idx = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (r_row_latch[k]) w_idx = AW'(k);
      end
   end

   assign w_nz    = |r_row_latch;
   assign w_multi = |(r_row_latch & (r_row_latch - 1'b1));
   assign w_wr    = r_dec & w_nz & ~w_multi;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) r_frame[i] <= '0;
         r_rd_data     <= '0;
         r_row_wr      <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
      end else begin
         if (w_wr) r_frame[w_idx] <= r_col_latch;
         r_rd_data    <= r_frame[rd_row];
         r_row_wr     <= w_wr;
         r_frame_done <= w_wr && (w_idx == AW'(WIDTH-1));
         if (w_wr && (w_idx == AW'(WIDTH-1))) r_frame_count <= r_frame_count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_multi <= 1'b0;
         r_err_len   <= 1'b0;
      end else begin
         if (r_dec && w_multi) r_err_multi <= 1'b1;
         else if (err_clr)     r_err_multi <= 1'b0;
         if (w_len_bad)        r_err_len   <= 1'b1;
         else if (err_clr)     r_err_len   <= 1'b0;
      end
   end

   assign rd_data     = r_rd_data;
   assign row_latch   = r_row_latch;
   assign col_latch   = r_col_latch;
   assign row_wr      = r_row_wr;
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign blank       = w_s[5];
   assign err_multi   = r_err_multi;
   assign err_len     = r_err_len;
endmodule
